// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    localparam int N_LEDS  = 5;
    localparam int SPEED_W = 2;
    localparam int CTR_W   = 25;
    localparam int POS_W   = 3;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic             DIR_UP  = 1'b0;
    localparam logic             DIR_DN  = 1'b1;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    function automatic logic [N_LEDS-1:0] led_onehot(input logic [POS_W-1:0] pos);
        return N_LEDS'(1) << pos;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle press pulse: 2-flop synchronizer, stability
// counter, and a registered rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int N_DEBOUNCE = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int               CNT_W    = $clog2(N_DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DEBOUNCE - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d      = {sync_q[0], i_btn};
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        // Count only while the synchronized level disagrees; any agreeing cycle restarts.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Five-LED pattern controller: mode FSM, speed select, shared step prescaler
// and pattern registers; buttons enter through two debouncers.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_CLKS_STEP = 5000000,
    parameter int N_DEBOUNCE  = 500000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_mode,
    input  logic              i_btn_speed,
    output logic [N_LEDS-1:0] o_leds,
    output logic [1:0]        o_mode
);

    localparam logic [CTR_W-1:0] STEP_BASE = CTR_W'(N_CLKS_STEP);

    logic press_mode, press_speed, restart, tick;

    mode_e              mode_q, mode_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d, period;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               phase_q, phase_d;
    logic [N_LEDS-1:0]  leds_q, leds_d;

    btn_debounce #(.N_DEBOUNCE(N_DEBOUNCE)) u_db_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_mode),
        .o_press (press_mode)
    );

    btn_debounce #(.N_DEBOUNCE(N_DEBOUNCE)) u_db_speed (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_speed),
        .o_press (press_speed)
    );

    assign restart = press_mode | press_speed;
    assign period  = STEP_BASE >> speed_q;
    assign tick    = (mode_q != MODE_OFF) && (ctr_q == period - CTR_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q  <= MODE_OFF;
            speed_q <= '0;
            ctr_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            phase_q <= 1'b1;
            leds_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            ctr_q   <= ctr_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press_mode) begin
            case (mode_q)
                MODE_OFF:    mode_d = MODE_CHASE;
                MODE_CHASE:  mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_BLINK;
                default:     mode_d = MODE_OFF;
            endcase
        end
    end

    always_comb begin
        speed_d = speed_q;
        ctr_d   = ctr_q + CTR_W'(1);
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        if (press_speed) begin
            speed_d = speed_q + SPEED_W'(1);
        end
        if (restart) begin
            ctr_d   = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            phase_d = 1'b1;
        end else if (mode_q == MODE_OFF) begin
            ctr_d = '0;
        end else if (tick) begin
            ctr_d = '0;
            case (mode_q)
                MODE_CHASE: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
                MODE_BOUNCE: begin
                    // Reverse at either end, so each end position is shown once per sweep.
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_MAX) begin
                            dir_d = DIR_DN;
                            pos_d = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = pos_q + POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_BLINK: phase_d = ~phase_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_d)
            MODE_CHASE, MODE_BOUNCE: leds_d = led_onehot(pos_d);
            MODE_BLINK:              leds_d = phase_d ? '1 : '0;
            default:                 leds_d = '0;
        endcase
    end

    assign o_leds = leds_q;
    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a cycle-level reference predicts every
// output change; a negedge monitor checks the DUT changes against it.
module tb_led_sequencer;

    localparam int N_STEP = 16;
    localparam int N_DEB  = 4;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_speed;
    logic [4:0] leds;
    logic [1:0] mode;

    led_sequencer #(.N_CLKS_STEP(N_STEP), .N_DEBOUNCE(N_DEB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_mode  (btn_mode),
        .i_btn_speed (btn_speed),
        .o_leds      (leds),
        .o_mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int mode;
        int leds;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    // Reference state: debounced levels as run lengths on raw samples,
    // presses as scheduled edges, outputs from time since last restart.
    int m_deb [2];
    int m_run [2];
    int ev_mode[$];
    int ev_speed[$];
    int m_mode, m_speed, m_rs, raw_v, per, k, j, exp_l;
    int prev_m, prev_l;
    bit pm, ps;
    exp_t e_new;

    initial begin : model
        m_deb = '{0, 0};
        m_run = '{0, 0};
        m_mode = 0; m_speed = 0; m_rs = 0; prev_m = 0; prev_l = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_deb = '{0, 0};
                m_run = '{0, 0};
                ev_mode.delete();
                ev_speed.delete();
                m_mode = 0; m_speed = 0; m_rs = cyc;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    raw_v = (b == 0) ? int'(btn_mode) : int'(btn_speed);
                    if (raw_v == m_deb[b]) begin
                        m_run[b] = 0;
                    end else begin
                        m_run[b]++;
                        if (m_run[b] == N_DEB) begin
                            m_deb[b] = raw_v;
                            m_run[b] = 0;
                            if (raw_v == 1) begin
                                if (b == 0) ev_mode.push_back(cyc + 4);
                                else        ev_speed.push_back(cyc + 4);
                            end
                        end
                    end
                end
                pm = (ev_mode.size() > 0) && (ev_mode[0] == cyc);
                ps = (ev_speed.size() > 0) && (ev_speed[0] == cyc);
                if (pm) begin void'(ev_mode.pop_front()); m_mode = (m_mode + 1) % 4; end
                if (ps) begin void'(ev_speed.pop_front()); m_speed = (m_speed + 1) % 4; end
                if (pm || ps) m_rs = cyc;
            end
            if (m_mode == 0) begin
                exp_l = 0;
            end else begin
                per = N_STEP >> m_speed;
                k = (cyc - m_rs) / per;
                case (m_mode)
                    1: exp_l = 1 << (k % 5);
                    2: begin j = k % 8; exp_l = 1 << ((j <= 4) ? j : 8 - j); end
                    default: exp_l = (k % 2 == 0) ? 31 : 0;
                endcase
            end
            if (m_mode != prev_m || exp_l != prev_l) begin
                e_new.cyc = cyc; e_new.mode = m_mode; e_new.leds = exp_l;
                sb_q.push_back(e_new);
                prev_m = m_mode; prev_l = exp_l;
            end
        end
    end

    int   mon_m = 0;
    int   mon_l = 0;
    exp_t e_got;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    e_got = sb_q.pop_front();
                    total++; bad++;
                    $display("FAIL missed_change at cyc=%0d: want mode=%0d leds=%05b, DUT still mode=%0d leds=%05b",
                             e_got.cyc, e_got.mode, e_got.leds[4:0], mode, leds);
                end
                if (int'(mode) != mon_m || int'(leds) != mon_l) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_change cyc=%0d got mode=%0d leds=%05b, want no change",
                                 cyc, mode, leds);
                    end else begin
                        e_got = sb_q.pop_front();
                        if (e_got.cyc != cyc || e_got.mode != int'(mode) || e_got.leds != int'(leds)) begin
                            bad++;
                            $display("FAIL output_change got cyc=%0d mode=%0d leds=%05b want cyc=%0d mode=%0d leds=%05b",
                                     cyc, mode, leds, e_got.cyc, e_got.mode, e_got.leds[4:0]);
                        end
                    end
                    mon_m = int'(mode);
                    mon_l = int'(leds);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit bm, input bit bs, input int hold);
        @(negedge clk);
        btn_mode = bm; btn_speed = bs;
        idle(hold);
        btn_mode = 1'b0; btn_speed = 1'b0;
    endtask

    int sel, hold, which, chat;

    initial begin : stim
        rst = 1'b1; btn_mode = 1'b0; btn_speed = 1'b0;
        idle(3);
        mon_en = 1'b1;
        rst = 1'b0;
        idle(100);
        chk("reset_leds", int'(leds), 0);
        chk("reset_mode", int'(mode), 0);

        press(1, 0, 10); idle(100);                   // CHASE
        for (int i = 0; i < 4; i++) begin press(0, 1, 10); idle(60); end
        press(1, 0, 10); idle(180);                   // BOUNCE
        press(1, 0, 3); idle(20);                     // short pulse
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin btn_mode = ~btn_mode; @(negedge clk); end
        btn_mode = 1'b0; idle(20);
        chk("glitch_mode", int'(mode), 2);
        press(1, 1, 10); idle(60);                    // BLINK + speed 1 together
        chk("simul_mode", int'(mode), 3);
        for (int i = 0; i < 3; i++) begin press(0, 1, 10); idle(40); end
        idle(40);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_leds", int'(leds), 0);
        chk("midrst_mode", int'(mode), 0);
        idle(100);
        press(0, 1, 10); idle(30);                    // speed in OFF
        chk("off_speed_leds", int'(leds), 0);
        @(negedge clk); btn_mode = 1'b1; rst = 1'b1;  // held through reset
        idle(3); rst = 1'b0;
        idle(10); btn_mode = 1'b0; idle(40);
        chk("held_rst_mode", int'(mode), 1);

        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 24);
            if (sel == 0) begin
                @(negedge clk); rst = 1'b1;
                idle($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                hold  = $urandom_range(1, 10);
                which = $urandom_range(1, 3);
                chat  = ($urandom_range(0, 3) == 0) ? 1 : 0;
                for (int c = 0; c < hold; c++) begin
                    @(negedge clk);
                    btn_mode  = which[0] & ((chat == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
                    btn_speed = which[1] & ((chat == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
                end
                @(negedge clk);
                btn_mode = 1'b0; btn_speed = 1'b0;
            end
            idle($urandom_range(0, 40));
        end

        @(negedge clk); rst = 1'b1;
        idle(3); rst = 1'b0;
        idle(10);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
